// File: rtl/ad_sample_sched.sv
// ADC conversion scheduler: arbitrates telemetry and periodic protection requests
// onto a single ADC reader, with trigger pulse, response timeout and inter-conversion gap.
module ad_sample_sched #(
  parameter int PROT_PERIOD_US = 50,
  parameter int TRIG_LEN       = 4,
  parameter int TIMEOUT_CLKS   = 2000
) (
  input  logic        clk,
  input  logic        Reset,
  input  logic        time_1us,
  input  logic        tele_req,
  input  logic        prot_en,
  output logic        ad_trigger,
  input  logic [11:0] ad_data,
  input  logic        ad_valid,
  output logic [11:0] tele_data,
  output logic        tele_valid,
  output logic [11:0] prot_data,
  output logic        prot_valid,
  output logic        busy,
  output logic        ad_timeout_err,
  input  logic        clr_err
);

  typedef enum logic [1:0] {IDLE, TRIG, WAIT, GAP} state_t;

  localparam logic [15:0] TRIG_LAST   = 16'(TRIG_LEN - 1);
  localparam logic [15:0] WAIT_LAST   = 16'(TIMEOUT_CLKS - 1);
  localparam logic [9:0]  PERIOD_LAST = 10'(PROT_PERIOD_US - 1);

  state_t      state, state_nx;
  logic        own;
  logic [15:0] cnt;
  logic [9:0]  prot_cnt;
  logic        tele_pend, prot_pend;
  logic        tele_req_q, tele_arm;
  logic        tele_edge, grant, timeout, prot_service;

  // tele_arm blocks a request level that was already high when reset released
  assign tele_edge    = tele_req & ~tele_req_q & tele_arm;
  assign grant        = (state == IDLE) & (tele_pend | prot_pend);
  assign timeout      = (state == WAIT) & ~ad_valid & (cnt == WAIT_LAST);
  assign prot_service = (state != IDLE) & own;

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (tele_pend || prot_pend) state_nx = TRIG;
      TRIG: if (cnt == TRIG_LAST) state_nx = WAIT;
      WAIT: if (ad_valid || cnt == WAIT_LAST) state_nx = GAP;
      GAP:  if (cnt == 16'd1) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    ad_trigger = (state == TRIG);
    busy       = (state != IDLE);
  end

  // cnt measures time spent in the current state and restarts on every transition
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      cnt <= '0;
      own <= 1'b0;
    end else begin
      if (state_nx != state) cnt <= '0;
      else if (state != IDLE) cnt <= cnt + 16'd1;
      if (grant) own <= prot_pend;
    end
  end

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      tele_req_q <= 1'b0;
      tele_arm   <= 1'b0;
      tele_pend  <= 1'b0;
    end else begin
      tele_req_q <= tele_req;
      if (!tele_req) tele_arm <= 1'b1;
      if (tele_edge) tele_pend <= 1'b1;
      else if (grant && !prot_pend) tele_pend <= 1'b0;
    end
  end

  // With prot_en low the period restarts, but an in-flight protection conversion is left alone
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      prot_cnt  <= '0;
      prot_pend <= 1'b0;
    end else begin
      if (!prot_en) begin
        if (!prot_service) prot_cnt <= '0;
      end else if (time_1us) begin
        if (prot_cnt == PERIOD_LAST) prot_cnt <= '0;
        else prot_cnt <= prot_cnt + 10'd1;
      end
      if (prot_en && time_1us && prot_cnt == PERIOD_LAST) prot_pend <= 1'b1;
      else if (grant) prot_pend <= 1'b0;
      else if (!prot_en && !prot_service) prot_pend <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      tele_data      <= '0;
      tele_valid     <= 1'b0;
      prot_data      <= '0;
      prot_valid     <= 1'b0;
      ad_timeout_err <= 1'b0;
    end else begin
      tele_valid <= 1'b0;
      prot_valid <= 1'b0;
      if (state == WAIT && ad_valid) begin
        if (own) begin
          prot_data  <= ad_data;
          prot_valid <= 1'b1;
        end else begin
          tele_data  <= ad_data;
          tele_valid <= 1'b1;
        end
      end
      if (timeout) ad_timeout_err <= 1'b1;
      else if (clr_err) ad_timeout_err <= 1'b0;
    end
  end

endmodule
